mic_record_ctrl: RTL and testbench

Capture sequencer for the microphone path: watches the 96 kHz sample strobe and 16-bit filtered samples leaving the PDM decimation/filter chain (already in the 100 MHz domain), arms on command, triggers on a sound-level threshold, decimates by a programmable factor and writes a bounded run of samples into an external single-port sample RAM. Status outputs expose progress to the processor-side register block, so firmware can start, abort and read back a recording without touching the filter chain.

---
 rtl/mic_record_ctrl.sv | 124 ++++++++++++
 tb/tb_mic_record_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mic_record_ctrl.sv
// Microphone capture sequencer: arms on command, triggers on sample magnitude,
// decimates and writes a bounded run of samples into an external sample RAM.
module mic_record_ctrl #(
   parameter int unsigned ADDR_W = 14
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              fs_i,
   input  logic [15:0]       data_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic [ADDR_W-1:0] length_i,
   input  logic [15:0]       thresh_i,
   input  logic [3:0]        decim_i,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [15:0]       mem_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [1:0]        state_o,
   output logic [ADDR_W:0]   count_o
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARMED  = 2'd1,
      S_RECORD = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t            state;
   logic              fs_q;
   logic [ADDR_W-1:0] length_l;
   logic [15:0]       thresh_l;
   logic [3:0]        decim_l;
   logic [3:0]        phase;
   logic              stb;
   logic              trig;
   logic              last;
   logic [15:0]       mag;

   assign stb     = fs_i & ~fs_q;
   // Two's-complement magnitude; -32768 maps to 32768 in unsigned 16 bits.
   assign mag     = data_i[15] ? (~data_i + 16'd1) : data_i;
   assign trig    = (mag >= thresh_l);
   assign last    = (count_o == {1'b0, length_l});
   assign state_o = state;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state      <= S_IDLE;
         fs_q       <= 1'b0;
         length_l   <= '0;
         thresh_l   <= '0;
         decim_l    <= '0;
         phase      <= '0;
         mem_we_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
         count_o    <= '0;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         fs_q     <= fs_i;
         mem_we_o <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               // A simultaneous stop suppresses the start.
               if (start_i && !stop_i) begin
                  state    <= S_ARMED;
                  busy_o   <= 1'b1;
                  done_o   <= 1'b0;
                  length_l <= length_i;
                  thresh_l <= thresh_i;
                  decim_l  <= decim_i;
                  count_o  <= '0;
                  phase    <= '0;
               end
            end
            S_ARMED: begin
               if (stop_i) begin
                  state  <= S_DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else if (stb && trig) begin
                  mem_we_o   <= 1'b1;
                  mem_addr_o <= count_o[ADDR_W-1:0];
                  mem_data_o <= data_i;
                  count_o    <= count_o + 1'b1;
                  phase      <= (decim_l != 4'd0) ? 4'd1 : 4'd0;
                  if (last) begin
                     state  <= S_DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                  end else begin
                     state  <= S_RECORD;
                  end
               end
            end
            S_RECORD: begin
               if (stop_i) begin
                  state  <= S_DONE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end else if (stb) begin
                  if (phase == 4'd0) begin
                     mem_we_o   <= 1'b1;
                     mem_addr_o <= count_o[ADDR_W-1:0];
                     mem_data_o <= data_i;
                     count_o    <= count_o + 1'b1;
                     if (last) begin
                        state  <= S_DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                     end
                  end
                  phase <= (phase == decim_l) ? 4'd0 : phase + 4'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mic_record_ctrl.sv
// Scoreboard bench for mic_record_ctrl with a 16-entry RAM (ADDR_W=4).
module tb_mic_record_ctrl;

   localparam int unsigned AW = 4;

   logic          clk_i = 1'b0;
   logic          rst_n_i = 1'b0;
   logic          fs_i = 1'b0;
   logic [15:0]   data_i = '0;
   logic          start_i = 1'b0;
   logic          stop_i = 1'b0;
   logic [AW-1:0] length_i = '0;
   logic [15:0]   thresh_i = '0;
   logic [3:0]    decim_i = '0;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [15:0]   mem_data_o;
   logic          busy_o;
   logic          done_o;
   logic [1:0]    state_o;
   logic [AW:0]   count_o;

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   wr_t q[$];
   int  tests = 0;
   int  failed = 0;

   mic_record_ctrl #(.ADDR_W(AW)) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .fs_i(fs_i), .data_i(data_i),
      .start_i(start_i), .stop_i(stop_i), .length_i(length_i),
      .thresh_i(thresh_i), .decim_i(decim_i), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .busy_o(busy_o),
      .done_o(done_o), .state_o(state_o), .count_o(count_o)
   );

   always #5 clk_i = ~clk_i;

   // Every RAM write must match the oldest expected entry.
   always @(negedge clk_i) begin
      if (rst_n_i && mem_we_o) begin
         tests++;
         if (q.size() == 0) begin
            failed++;
            $display("FAIL unexpected_write: got addr %0d data %0h, required no write",
                     mem_addr_o, mem_data_o);
         end else begin
            wr_t e;
            e = q.pop_front();
            if (mem_addr_o !== e.addr || mem_data_o !== e.data) begin
               failed++;
               $display("FAIL write: got addr %0d data %0h, required addr %0d data %0h",
                        mem_addr_o, mem_data_o, e.addr, e.data);
            end
         end
      end
   end

   task automatic expect_wr(input logic [AW-1:0] a, input logic [15:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      q.push_back(e);
   endtask

   task automatic cfg(input logic [AW-1:0] len, input logic [15:0] th, input logic [3:0] dec);
      length_i = len;
      thresh_i = th;
      decim_i  = dec;
   endtask

   task automatic pulse(input logic s, input logic p);
      @(posedge clk_i); #1;
      start_i = s;
      stop_i  = p;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      stop_i  = 1'b0;
      @(negedge clk_i);
   endtask

   task automatic send(input logic [15:0] d, input int unsigned width);
      @(posedge clk_i); #1;
      data_i = d;
      fs_i   = 1'b1;
      repeat (width) @(posedge clk_i);
      #1 fs_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic check_drained(input string name);
      tests++;
      if (q.size() !== 0) begin
         failed++;
         $display("FAIL %s_drained: got %0d writes pending, required 0", name, q.size());
      end
      q.delete();
   endtask

   task automatic check_st(input string name, input logic [1:0] st, input logic [AW:0] cnt);
      tests++;
      if (state_o !== st || count_o !== cnt || busy_o !== (st == 2'd1 || st == 2'd2) ||
          done_o !== (st == 2'd3)) begin
         failed++;
         $display("FAIL %s: got state %0d count %0d busy %b done %b, required state %0d count %0d",
                  name, state_o, count_o, busy_o, done_o, st, cnt);
      end
   endtask

   task automatic test_reset;
      #1;
      tests++;
      if ({mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, state_o, count_o} !== '0) begin
         failed++;
         $display("FAIL reset_outputs: got we %b addr %0d data %0h busy %b done %b state %0d count %0d, required all 0",
                  mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, state_o, count_o);
      end
      #20 rst_n_i = 1'b1;
      pulse(1'b0, 1'b1);
      check_st("idle_stop_ignored", 2'd0, 5'd0);
   endtask

   task automatic test_basic;
      cfg(4'd3, 16'd0, 4'd0);
      pulse(1'b1, 1'b0);
      check_st("basic_armed", 2'd1, 5'd0);
      for (int i = 0; i < 4; i++) expect_wr(AW'(i), 16'((i + 1) * 10));
      for (int i = 0; i < 6; i++) send(16'((i + 1) * 10), 1);
      check_st("basic_done", 2'd3, 5'd4);
      check_drained("basic");
   endtask

   task automatic test_trigger;
      cfg(4'd1, 16'd1000, 4'd0);
      pulse(1'b1, 1'b0);
      expect_wr(4'd0, 16'hFC18);
      expect_wr(4'd1, 16'd5);
      send(16'd100, 1);
      send(16'hFC19, 1);
      check_st("trig_not_yet", 2'd1, 5'd0);
      send(16'hFC18, 1);
      send(16'd5, 1);
      check_st("trig_done", 2'd3, 5'd2);
      check_drained("trigger");
      cfg(4'd0, 16'h8000, 4'd0);
      pulse(1'b1, 1'b0);
      expect_wr(4'd0, 16'h8000);
      send(16'h7FFF, 1);
      send(16'h8000, 1);
      check_st("trig_min_neg", 2'd3, 5'd1);
      check_drained("trigger_min");
   endtask

   task automatic test_decim;
      cfg(4'd2, 16'd0, 4'd2);
      pulse(1'b1, 1'b0);
      expect_wr(4'd0, 16'd1);
      expect_wr(4'd1, 16'd4);
      expect_wr(4'd2, 16'd7);
      for (int i = 1; i <= 9; i++) send(16'(i), 1);
      check_st("decim_done", 2'd3, 5'd3);
      check_drained("decim");
   endtask

   task automatic test_abort;
      cfg(4'd12, 16'd0, 4'd0);
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) expect_wr(AW'(i), 16'(100 + i));
      for (int i = 0; i < 5; i++) send(16'(100 + i), 1);
      @(posedge clk_i); #1;
      data_i = 16'd999;
      fs_i   = 1'b1;
      stop_i = 1'b1;
      @(posedge clk_i); #1;
      fs_i   = 1'b0;
      stop_i = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check_st("abort_done", 2'd3, 5'd5);
      check_drained("abort");
      pulse(1'b1, 1'b1);
      check_st("done_start_stop", 2'd3, 5'd5);
      pulse(1'b1, 1'b0);
      check_st("abort_rearm", 2'd1, 5'd0);
   endtask

   task automatic test_strobe_width;
      expect_wr(4'd0, 16'h1234);
      send(16'h1234, 10);
      check_st("wide_strobe", 2'd2, 5'd1);
      check_drained("wide_strobe");
      pulse(1'b1, 1'b0);
      check_st("record_start_ignored", 2'd2, 5'd1);
      pulse(1'b0, 1'b1);
      check_st("record_stop", 2'd3, 5'd1);
   endtask

   task automatic test_async_reset;
      cfg(4'd10, 16'd0, 4'd0);
      pulse(1'b1, 1'b0);
      expect_wr(4'd0, 16'd11);
      expect_wr(4'd1, 16'd22);
      send(16'd11, 1);
      send(16'd22, 1);
      check_drained("pre_reset");
      @(posedge clk_i); #1;
      data_i = 16'd77;
      fs_i   = 1'b1;
      @(posedge clk_i); #2;
      rst_n_i = 1'b0;
      #1;
      tests++;
      if ({mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, state_o, count_o} !== '0) begin
         failed++;
         $display("FAIL async_reset: got we %b addr %0d data %0h busy %b done %b state %0d count %0d, required all 0",
                  mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o, state_o, count_o);
      end
      fs_i = 1'b0;
      #20 rst_n_i = 1'b1;
      send(16'd33, 1);
      send(16'd44, 1);
      check_st("post_reset_idle", 2'd0, 5'd0);
      pulse(1'b1, 1'b1);
      check_st("idle_start_stop", 2'd0, 5'd0);
   endtask

   task automatic test_full;
      cfg(4'd15, 16'd0, 4'd0);
      pulse(1'b1, 1'b0);
      for (int i = 0; i < 16; i++) expect_wr(AW'(i), 16'(i * 3 + 1));
      for (int i = 0; i < 17; i++) send(16'(i * 3 + 1), 1);
      check_st("full_done", 2'd3, 5'd16);
      check_drained("full");
   endtask

   initial begin
      test_reset();
      test_basic();
      test_trigger();
      test_decim();
      test_abort();
      test_strobe_width();
      test_async_reset();
      test_full();
      repeat (5) @(posedge clk_i);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
